// File: rtl/div_unit_pkg.sv
// cpu_defs: shared divider constants and state encoding
package cpu_defs;
  localparam int DIV_WIDTH = 32;
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;
endpackage

// File: rtl/div_unit_step.sv
// div_step: one restoring division iteration on {rem,quo}
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  // shift in the next dividend bit, keep the difference only when it stays non-negative
  always_comb begin
    shifted = {remIn, quoIn[WIDTH-1]};
    trial = shifted - {1'b0, divisor};
    remOut = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quoOut = {quoIn[WIDTH-2:0], ~trial[WIDTH]};
  end
endmodule

// File: rtl/div_unit.sv
// div_unit: multicycle radix-2 restoring DIV/DIVU with pipeline stall handshake
module div_unit
  import cpu_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             annulE,
  input  logic             holdE,
  output logic             stall_divE,
  output logic             readyE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE
);
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] remReg, quoReg, divisorReg;
  logic [WIDTH-1:0] absA, absB, stepRem, stepQuo, remFix, quoFix;
  logic negQ, negR;

  div_step #(.WIDTH(WIDTH)) step (
    .remIn(remReg),
    .quoIn(quoReg),
    .divisor(divisorReg),
    .remOut(stepRem),
    .quoOut(stepQuo)
  );

  // stall/ready handshake plus operand magnitudes and sign-corrected step result
  always_comb begin
    stall_divE = !annulE && ((state == DIV_IDLE && startE) || state == DIV_BUSY);
    readyE = !annulE && state == DIV_DONE;
    absA = (signedE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
    absB = (signedE && srcbE[WIDTH-1]) ? -srcbE : srcbE;
    quoFix = negQ ? -stepQuo : stepQuo;
    remFix = negR ? -stepRem : stepRem;
  end

  // FSM: capture, iterate WIDTH steps, present result until the EX stage moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt <= '0;
      remReg <= '0;
      quoReg <= '0;
      divisorReg <= '0;
      negQ <= 1'b0;
      negR <= 1'b0;
      hiE <= '0;
      loE <= '0;
    end else if (annulE) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (startE) begin
          if (srcbE == '0) begin
            hiE <= srcaE;
            loE <= WIDTH'(DIV_ZERO_LO);
            state <= DIV_DONE;
          end else begin
            remReg <= '0;
            quoReg <= absA;
            divisorReg <= absB;
            negQ <= signedE && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            negR <= signedE && srcaE[WIDTH-1];
            cnt <= '0;
            state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          remReg <= stepRem;
          quoReg <= stepQuo;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            hiE <= remFix;
            loE <= quoFix;
            state <= DIV_DONE;
          end
        end
        DIV_DONE: if (!holdE) state <= DIV_IDLE;
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors against a timeline/arithmetic reference model
module tb_div_unit;
  logic clk = 1'b0, rst = 1'b1, startE = 1'b0, signedE = 1'b0, annulE = 1'b0, holdE = 1'b0;
  logic [31:0] srcaE = '0, srcbE = '0;
  logic stall_divE, readyE;
  logic [31:0] hiE, loE;
  int nChecks = 0, nPass = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .startE(startE), .signedE(signedE),
    .srcaE(srcaE), .srcbE(srcbE), .annulE(annulE), .holdE(holdE),
    .stall_divE(stall_divE), .readyE(readyE), .hiE(hiE), .loE(loE)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  function automatic logic [63:0] refDiv(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // reference: cycles since capture; 33 stall cycles total (1 for divide by zero)
  bit mActive = 0;
  int mAge = 0, mLen = 0;
  logic [63:0] mRes = '0;
  logic [31:0] mOutHi = '0, mOutLo = '0;

  always @(posedge clk) begin
    if (rst) begin
      mActive <= 0;
      mOutHi <= '0;
      mOutLo <= '0;
    end else if (annulE) mActive <= 0;
    else if (!mActive) begin
      if (startE) begin
        mActive <= 1;
        mAge <= 1;
        mLen <= (srcbE == 0) ? 1 : 33;
        mRes <= refDiv(signedE, srcaE, srcbE);
        if (srcbE == 0) {mOutHi, mOutLo} <= refDiv(signedE, srcaE, srcbE);
      end
    end else if (mAge >= mLen) begin
      if (!holdE) mActive <= 0;
    end else begin
      mAge <= mAge + 1;
      if (mAge + 1 == mLen) {mOutHi, mOutLo} <= mRes;
    end
  end

  always @(negedge clk) begin
    logic expStall, expReady;
    if (!rst) begin
      expStall = !mActive ? (startE && !annulE) : (mAge < mLen ? !annulE : 1'b0);
      expReady = mActive && mAge >= mLen && !annulE;
      check("m_stall", {31'b0, stall_divE}, {31'b0, expStall});
      check("m_ready", {31'b0, readyE}, {31'b0, expReady});
      check("m_hi", hiE, mOutHi);
      check("m_lo", loE, mOutLo);
    end
  end

  task automatic runOp(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eLo, input logic [31:0] eHi, input int eStall, input bit keepStart);
    int st = 0;
    bit got = 0;
    @(posedge clk);
    #1;
    startE = 1; signedE = s; srcaE = a; srcbE = b;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (readyE) got = 1;
      else if (stall_divE) st++;
    end
    check({nm, "_done"}, {31'b0, got}, 32'd1);
    check({nm, "_lo"}, loE, eLo);
    check({nm, "_hi"}, hiE, eHi);
    check({nm, "_stalls"}, st, eStall);
    if (!keepStart) begin
      @(posedge clk);
      #1;
      startE = 0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("rst_stall", {31'b0, stall_divE}, 32'd0);
    check("rst_ready", {31'b0, readyE}, 32'd0);
    check("rst_lo", loE, 32'd0);
    runOp("divu_100_7", 0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);
    runOp("div_m100_7", 1, -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, 0);
    runOp("div_min_m1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 0);
    runOp("divu_5_0", 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 0);
    runOp("div_m5_0", 1, -32'sd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 0);
    runOp("div_7_m2", 1, 32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1, 33, 0);
    runOp("div_m7_m2", 1, -32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, 33, 0);
    runOp("divu_max_1", 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 0);
    runOp("divu_3_10", 0, 32'd3, 32'd10, 32'd0, 32'd3, 33, 0);
    runOp("divu_big", 0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 33, 0);
    // annul while iterating, then a fresh full-length operation
    @(posedge clk);
    #1;
    startE = 1; signedE = 0; srcaE = 32'd1000; srcbE = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    annulE = 1;
    @(negedge clk);
    check("annul_stall", {31'b0, stall_divE}, 32'd0);
    check("annul_ready", {31'b0, readyE}, 32'd0);
    @(posedge clk);
    #1;
    annulE = 0; startE = 0;
    @(negedge clk);
    check("annul_idle_stall", {31'b0, stall_divE}, 32'd0);
    runOp("after_annul", 0, 32'd1000, 32'd3, 32'd333, 32'd1, 33, 0);
    // annul beats start in the capture cycle
    @(posedge clk);
    #1;
    startE = 1; annulE = 1; srcaE = 32'd9; srcbE = 32'd2;
    @(negedge clk);
    check("annul_start_stall", {31'b0, stall_divE}, 32'd0);
    @(posedge clk);
    #1;
    startE = 0; annulE = 0;
    @(negedge clk);
    check("annul_start_idle", {31'b0, stall_divE}, 32'd0);
    // hold in DONE must not restart; release then back-to-back start
    runOp("hold_op", 0, 32'd50, 32'd6, 32'd8, 32'd2, 33, 1);
    holdE = 1;
    repeat (4) begin
      @(negedge clk);
      check("hold_ready", {31'b0, readyE}, 32'd1);
      check("hold_stall", {31'b0, stall_divE}, 32'd0);
      check("hold_lo", loE, 32'd8);
    end
    holdE = 0;
    runOp("b2b_op", 1, -32'sd50, 32'd6, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 33, 0);
    // synchronous reset in the middle of an operation
    @(posedge clk);
    #1;
    startE = 1; signedE = 0; srcaE = 32'd77; srcbE = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0; startE = 0;
    @(negedge clk);
    check("rst_mid_stall", {31'b0, stall_divE}, 32'd0);
    check("rst_mid_ready", {31'b0, readyE}, 32'd0);
    check("rst_mid_hi", hiE, 32'd0);
    check("rst_mid_lo", loE, 32'd0);
    runOp("after_rst", 0, 32'd77, 32'd5, 32'd15, 32'd2, 33, 0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
